// File: rtl/io_controller.sv
// io_controller: IN/OUT unit for the single-cycle core.
// Debounced switch capture plus a sequential binary-to-BCD seven-segment driver.
module io_controller #(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 16,
    parameter int DIGITS       = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter bit SIGNED_IN    = 1'b1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                halt,
    input  logic                in_req,
    input  logic                out_req,
    input  logic [DATA_W-1:0]   out_data,
    input  logic [SW_W-1:0]     SW,
    input  logic                insert,
    output logic                stall,
    output logic                in_ack,
    output logic [DATA_W-1:0]   user_input,
    output logic                out_busy,
    output logic                out_ovf,
    output logic [7*DIGITS-1:0] hex
);

    localparam int NBCD  = (DATA_W * 302 + 999) / 1000 + 1;
    localparam int TOT   = (NBCD > DIGITS) ? NBCD : DIGITS;
    localparam int MSD_W = $clog2(NBCD + 1);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [7*DIGITS-1:0] HEX_RST =
        {{(7*DIGITS-7){1'b1}}, 7'b1000000};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // ---------------- insert conditioning ----------------
    logic            sync1_q, sync2_q;
    logic            db_q, db_d, db_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            ins_rise;

    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (sync2_q != db_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                db_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    assign ins_rise = db_q & ~db_prev_q;

    // ---------------- IN path ----------------
    typedef enum logic [1:0] {
        IN_IDLE,
        IN_WAIT_PRESS,
        IN_ACK,
        IN_WAIT_REL
    } in_state_e;

    in_state_e         in_state_q, in_state_d;
    logic              in_ack_q, in_ack_d;
    logic [DATA_W-1:0] user_input_q, user_input_d;
    logic [DATA_W-1:0] sw_ext;
    logic              ext_bit;
    logic              in_stall;

    always_comb begin
        ext_bit             = SIGNED_IN & SW[SW_W-1];
        sw_ext              = {DATA_W{ext_bit}};
        sw_ext[SW_W-1:0]    = SW;
    end

    always_comb begin
        in_state_d   = in_state_q;
        user_input_d = user_input_q;
        unique case (in_state_q)
            IN_IDLE: begin
                if (in_req && !halt) in_state_d = IN_WAIT_PRESS;
            end
            IN_WAIT_PRESS: begin
                if (halt || !in_req) begin
                    in_state_d = IN_IDLE;
                end else if (ins_rise) begin
                    in_state_d   = IN_ACK;
                    user_input_d = sw_ext;
                end
            end
            IN_ACK: begin
                in_state_d = IN_WAIT_REL;
            end
            IN_WAIT_REL: begin
                if (!db_q) in_state_d = IN_IDLE;
            end
            default: in_state_d = IN_IDLE;
        endcase
        in_ack_d = (in_state_d == IN_ACK);
    end

    // The instruction is held in every state except the commit cycle.
    assign in_stall = in_req & ~halt & (in_state_q != IN_ACK);

    // ---------------- OUT path ----------------
    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_CONV,
        OUT_DONE
    } out_state_e;

    out_state_e          out_state_q, out_state_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   bin_q, bin_d;
    logic [4*NBCD-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic [DATA_W-1:0]   mag;
    logic [4*NBCD-1:0]   adj;

    assign mag = out_data[DATA_W-1] ? (~out_data + DATA_W'(1)) : out_data;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Display image of the finished conversion.
    logic [4*TOT-1:0]    dig_all;
    logic [MSD_W-1:0]    msd;
    logic                disp_ovf;
    logic [7*DIGITS-1:0] disp;

    always_comb begin
        dig_all             = '0;
        dig_all[4*NBCD-1:0] = bcd_q;
        msd                 = '0;
        disp_ovf            = 1'b0;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                msd = MSD_W'(i);
                if (i >= DIGITS) disp_ovf = 1'b1;
            end
        end
        if (neg_q && int'(msd) >= DIGITS - 1) disp_ovf = 1'b1;
        disp = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (disp_ovf) begin
                disp[7*k +: 7] = SEG_DASH;
            end else if (k <= int'(msd)) begin
                disp[7*k +: 7] = seg7(dig_all[4*k +: 4]);
            end else if (neg_q && k == int'(msd) + 1) begin
                disp[7*k +: 7] = SEG_DASH;
            end else begin
                disp[7*k +: 7] = SEG_BLANK;
            end
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        neg_d       = neg_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        hex_d       = hex_q;
        ovf_d       = ovf_q;
        unique case (out_state_q)
            OUT_IDLE: begin
                if (out_req && !halt) begin
                    out_state_d = OUT_CONV;
                    neg_d       = out_data[DATA_W-1];
                    bin_d       = mag;
                    bcd_d       = '0;
                    cnt_d       = '0;
                end
            end
            OUT_CONV: begin
                bcd_d = (adj << 1) | (4*NBCD)'(bin_q[DATA_W-1]);
                bin_d = bin_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) out_state_d = OUT_DONE;
            end
            OUT_DONE: begin
                hex_d       = disp;
                ovf_d       = disp_ovf;
                out_state_d = OUT_IDLE;
            end
            default: out_state_d = OUT_IDLE;
        endcase
        busy_d = (out_state_d != OUT_IDLE);
    end

    // ---------------- state ----------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            db_q         <= 1'b0;
            db_prev_q    <= 1'b0;
            db_cnt_q     <= '0;
            in_state_q   <= IN_IDLE;
            in_ack_q     <= 1'b0;
            user_input_q <= '0;
            out_state_q  <= OUT_IDLE;
            neg_q        <= 1'b0;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
            hex_q        <= HEX_RST;
        end else begin
            sync1_q      <= insert;
            sync2_q      <= sync1_q;
            db_q         <= db_d;
            db_prev_q    <= db_q;
            db_cnt_q     <= db_cnt_d;
            in_state_q   <= in_state_d;
            in_ack_q     <= in_ack_d;
            user_input_q <= user_input_d;
            out_state_q  <= out_state_d;
            neg_q        <= neg_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            ovf_q        <= ovf_d;
            hex_q        <= hex_d;
        end
    end

    assign stall      = in_stall | (out_req & (out_state_q != OUT_IDLE));
    assign in_ack     = in_ack_q;
    assign user_input = user_input_q;
    assign out_busy   = busy_q;
    assign out_ovf    = ovf_q;
    assign hex        = hex_q;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: display conversions, IN handshake,
// busy collisions, halt and reset behaviour.
module tb_io_controller;

    logic        CLK = 1'b0;
    logic        reset, halt, in_req, out_req, insert;
    logic [31:0] out_data;
    logic [15:0] SW;

    logic        stall, in_ack, out_busy, out_ovf;
    logic [31:0] user_input;
    logic [55:0] hex;

    logic        stall_u, in_ack_u, out_busy_u, out_ovf_u;
    logic [31:0] user_input_u;
    logic [55:0] hex_u;

    int n_run  = 0;
    int n_fail = 0;
    int ack_cnt = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    io_controller u_dut (
        .CLK(CLK), .reset(reset), .halt(halt),
        .in_req(in_req), .out_req(out_req), .out_data(out_data),
        .SW(SW), .insert(insert),
        .stall(stall), .in_ack(in_ack), .user_input(user_input),
        .out_busy(out_busy), .out_ovf(out_ovf), .hex(hex)
    );

    io_controller #(.SIGNED_IN(1'b0)) u_dut_u (
        .CLK(CLK), .reset(reset), .halt(halt),
        .in_req(in_req), .out_req(out_req), .out_data(out_data),
        .SW(SW), .insert(insert),
        .stall(stall_u), .in_ack(in_ack_u), .user_input(user_input_u),
        .out_busy(out_busy_u), .out_ovf(out_ovf_u), .hex(hex_u)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (in_ack) ack_cnt++;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Issue one OUT and wait for the conversion to finish.
    task automatic show(input logic [31:0] v, output int busy_n);
        out_req  = 1'b1;
        out_data = v;
        #1;
        chk("acc_stall", stall, 1'b0);
        step();
        out_req = 1'b0;
        busy_n  = 0;
        for (int i = 0; i < 100 && out_busy; i++) begin
            busy_n++;
            step();
        end
        chk("busy_done", out_busy, 1'b0);
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (in_ack) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bn, lat, a0, stall_n;
        reset = 1'b1; halt = 1'b0; in_req = 1'b0; out_req = 1'b0;
        insert = 1'b0; out_data = '0; SW = '0;
        steps(2);
        reset = 1'b0;

        chk("rst_stall", stall, 1'b0);
        chk("rst_ack", in_ack, 1'b0);
        chk("rst_uin", user_input, 32'h0);
        chk("rst_busy", out_busy, 1'b0);
        chk("rst_ovf", out_ovf, 1'b0);
        chk("rst_hex", hex, {{7{BL}}, S0});

        // Display values
        show(32'd1234, bn);
        chk("busy_len", bn, 33);
        chk("hex_1234", hex, {{4{BL}}, S1, S2, S3, S4});
        chk("ovf_1234", out_ovf, 1'b0);

        show(-32'sd5, bn);
        chk("hex_m5", hex, {{6{BL}}, DS, S5});
        chk("ovf_m5", out_ovf, 1'b0);

        show(32'd99999999, bn);
        chk("hex_8x9", hex, {8{S9}});
        chk("ovf_8x9", out_ovf, 1'b0);

        show(-32'sd9999999, bn);
        chk("hex_m7x9", hex, {DS, {7{S9}}});
        chk("ovf_m7x9", out_ovf, 1'b0);

        show(-32'sd12345678, bn);
        chk("ovf_m8dig", out_ovf, 1'b1);
        chk("hex_m8dig", hex, {8{DS}});

        show(32'd0, bn);
        chk("hex_zero", hex, {{7{BL}}, S0});
        chk("ovf_zero", out_ovf, 1'b0);

        show(32'd100000000, bn);
        chk("ovf_9dig", out_ovf, 1'b1);

        show(32'h80000000, bn);
        chk("ovf_min", out_ovf, 1'b1);
        chk("hex_min", hex, {8{DS}});

        // Busy collision: second OUT arrives during conversion
        out_req  = 1'b1;
        out_data = 32'd1;
        #1;
        chk("col_acc1", stall, 1'b0);
        step();
        out_data = 32'd42;
        stall_n  = 0;
        for (int i = 0; i < 100 && stall; i++) begin
            stall_n++;
            step();
        end
        chk("col_stall_len", stall_n, 33);
        chk("col_hex1", hex, {{7{BL}}, S1});
        step();
        out_req = 1'b0;
        chk("col_busy2", out_busy, 1'b1);
        for (int i = 0; i < 100 && out_busy; i++) step();
        chk("col_hex2", hex, {{6{BL}}, S4, S2});

        // IN with glitches, clean press, held button
        SW     = 16'h8001;
        in_req = 1'b1;
        #1;
        chk("in_stall0", stall, 1'b1);
        a0 = ack_cnt;
        insert = 1'b1;
        steps(3);
        insert = 1'b0;
        steps(8);
        chk("glitch_noack", ack_cnt - a0, 0);
        chk("glitch_stall", stall, 1'b1);

        insert = 1'b1;
        wait_ack(lat);
        chk("press_lat_ok", (lat >= 1) && (lat <= 8), 1'b1);
        chk("uin_signed", user_input, 32'hFFFF8001);
        chk("uin_unsigned", user_input_u, 32'h00008001);
        chk("ack_stall", stall, 1'b0);
        step();
        chk("ack_pulse", in_ack, 1'b0);
        chk("held_stall", stall, 1'b1);
        steps(12);
        chk("held_one_ack", ack_cnt - a0, 1);
        insert = 1'b0;
        SW     = 16'h1234;
        steps(10);
        chk("rel_noack", ack_cnt - a0, 1);
        chk("rel_stall", stall, 1'b1);
        insert = 1'b1;
        wait_ack(lat);
        chk("press2_lat_ok", (lat >= 1) && (lat <= 8), 1'b1);
        chk("uin_press2", user_input, 32'h00001234);
        in_req = 1'b0;
        step();
        insert = 1'b0;
        steps(10);

        // halt during WAIT_PRESS
        SW     = 16'h5555;
        in_req = 1'b1;
        step();
        chk("wp_stall", stall, 1'b1);
        halt = 1'b1;
        #1;
        chk("halt_stall", stall, 1'b0);
        a0 = ack_cnt;
        step();
        insert = 1'b1;
        steps(12);
        chk("halt_noack", ack_cnt - a0, 0);
        chk("halt_nocap", user_input, 32'h00001234);
        in_req = 1'b0;
        halt   = 1'b0;
        insert = 1'b0;
        steps(10);

        // halt: running conversion completes, new OUT not accepted
        out_req  = 1'b1;
        out_data = 32'd7;
        step();
        out_req = 1'b0;
        halt    = 1'b1;
        for (int i = 0; i < 100 && out_busy; i++) step();
        chk("halt_conv_hex", hex, {{7{BL}}, S7});
        out_req  = 1'b1;
        out_data = 32'd3;
        step();
        chk("halt_noacc", out_busy, 1'b0);
        out_req = 1'b0;
        halt    = 1'b0;
        step();

        // Reset mid-conversion and during WAIT_PRESS
        show(32'h80000000, bn);
        out_req  = 1'b1;
        out_data = 32'd42;
        in_req   = 1'b1;
        step();
        out_req = 1'b0;
        steps(10);
        chk("pre_rst_busy", out_busy, 1'b1);
        chk("pre_rst_stall", stall, 1'b1);
        reset  = 1'b1;
        in_req = 1'b0;
        step();
        reset = 1'b0;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_ack", in_ack, 1'b0);
        chk("mid_rst_uin", user_input, 32'h0);
        chk("mid_rst_busy", out_busy, 1'b0);
        chk("mid_rst_ovf", out_ovf, 1'b0);
        chk("mid_rst_hex", hex, {{7{BL}}, S0});
        steps(40);
        chk("rst_aborted", hex, {{7{BL}}, S0});

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
